// File: rtl/dmac_xfer_ctrl_if.sv
// Bus master port of the DMAC transfer engine: request/grant handshake plus one
// strobed read or write per bus cycle.
`timescale 1ns/1ps
interface dmac_xfer_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_grant;
  logic              m_sel;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req, m_sel, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_sel, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );
endinterface

// File: rtl/dmac_xfer_ctrl.sv
// DMAC transfer engine: pops (src, dest, size) descriptors and copies words over the bus.
// Optional grant-wait timeout with ERROR status is enabled by defining DMAC_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module dmac_xfer_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int SIZE_W         = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic [1:0]        op_mode,
  input  logic              opdone_clear,
  input  logic              fifo_empty,
  input  logic [ADDR_W-1:0] fifo_src_addr,
  input  logic [ADDR_W-1:0] fifo_dest_addr,
  input  logic [SIZE_W-1:0] fifo_data_size,
  output logic              fifo_rd_en,
  dmac_xfer_ctrl_if.master  bus,
  output logic [1:0]        status
);

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_LOAD, S_RD, S_RDW, S_WR, S_REL, S_DONE, S_ERROR
  } state_t;

  state_t            state_reg;
  logic              op_start_q_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dest_reg;
  logic [SIZE_W-1:0] size_reg;
  logic [1:0]        mode_reg;
  logic [DATA_W-1:0] data_reg;

  logic start_edge;
  logic stalled;

  assign start_edge = op_start & ~op_start_q_reg;
  assign stalled    = ((state_reg == S_RD) || (state_reg == S_WR)) && !bus.m_grant;

`ifdef DMAC_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timeout_cnt_reg;
  logic            timeout_hit;
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign timeout_hit = stalled && (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = stalled ^ (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      op_start_q_reg <= 1'b0;
      src_reg        <= '0;
      dest_reg       <= '0;
      size_reg       <= '0;
      mode_reg       <= '0;
      data_reg       <= '0;
      status         <= 2'b00;
      fifo_rd_en     <= 1'b0;
      bus.m_req      <= 1'b0;
      bus.m_sel      <= 1'b0;
      bus.m_wr       <= 1'b0;
      bus.m_addr     <= '0;
      bus.m_dout     <= '0;
`ifdef DMAC_CTRL_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      op_start_q_reg <= op_start;
      fifo_rd_en     <= 1'b0;
      bus.m_sel      <= 1'b0;
      bus.m_wr       <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start_edge) begin
            state_reg <= S_POP;
            status    <= 2'b01;
          end
        end
        S_POP: begin
          if (fifo_empty) begin
            state_reg <= S_DONE;
            status    <= 2'b10;
          end else begin
            fifo_rd_en <= 1'b1;
            src_reg    <= fifo_src_addr;
            dest_reg   <= fifo_dest_addr;
            size_reg   <= fifo_data_size;
            mode_reg   <= op_mode;
            state_reg  <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A zero-length descriptor is consumed without requesting the bus.
          if (size_reg == '0) begin
            state_reg <= S_POP;
          end else begin
            bus.m_req <= 1'b1;
            state_reg <= S_RD;
          end
        end
        S_RD: begin
          if (bus.m_grant) begin
            bus.m_sel  <= 1'b1;
            bus.m_addr <= src_reg;
            state_reg  <= S_RDW;
          end
        end
        S_RDW: begin
          data_reg  <= bus.m_din;
          state_reg <= S_WR;
        end
        S_WR: begin
          if (bus.m_grant) begin
            bus.m_sel  <= 1'b1;
            bus.m_wr   <= 1'b1;
            bus.m_addr <= dest_reg;
            bus.m_dout <= data_reg;
            size_reg   <= size_reg - SIZE_W'(1);
            if (mode_reg != 2'b01) src_reg  <= src_reg + ADDR_W'(1);
            if (mode_reg != 2'b10) dest_reg <= dest_reg + ADDR_W'(1);
            state_reg  <= (size_reg == SIZE_W'(1)) ? S_REL : S_RD;
          end
        end
        S_REL: begin
          bus.m_req <= 1'b0;
          state_reg <= S_POP;
        end
        S_DONE, S_ERROR: begin
          if (opdone_clear) begin
            state_reg <= S_IDLE;
            status    <= 2'b00;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          status    <= 2'b00;
        end
      endcase

`ifdef DMAC_CTRL_TIMEOUT_EN
      // Overrides the stall decision above once the grant wait is exhausted.
      if (timeout_hit) begin
        state_reg       <= S_ERROR;
        status          <= 2'b11;
        bus.m_req       <= 1'b0;
        timeout_cnt_reg <= '0;
      end else if (stalled) begin
        timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
      end else begin
        timeout_cnt_reg <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmac_xfer_ctrl.sv
// Randomised bench for dmac_xfer_ctrl: a descriptor queue and an address-derived read
// pattern feed the DUT; bus strobes are logged and compared with a list-level model.
`timescale 1ns/1ps
module tb_dmac_xfer_ctrl;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 5;

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dest;
    logic [SW-1:0] size;
  } desc_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          op_start = 1'b0;
  logic [1:0]    op_mode = 2'b00;
  logic          opdone_clear = 1'b0;
  logic          fifo_empty;
  logic [AW-1:0] fifo_src_addr;
  logic [AW-1:0] fifo_dest_addr;
  logic [SW-1:0] fifo_data_size;
  logic          fifo_rd_en;
  logic [1:0]    status;

  dmac_xfer_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  dmac_xfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT_CYCLES(255)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .op_start       (op_start),
    .op_mode        (op_mode),
    .opdone_clear   (opdone_clear),
    .fifo_empty     (fifo_empty),
    .fifo_src_addr  (fifo_src_addr),
    .fifo_dest_addr (fifo_dest_addr),
    .fifo_data_size (fifo_data_size),
    .fifo_rd_en     (fifo_rd_en),
    .bus            (bus_if),
    .status         (status)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] seed = 32'h1234_5678;
  desc_t       fq[$];
  desc_t       plan_q[$];
  xfer_t       log_q[$];
  int          log_cyc[$];
  xfer_t       exp_q[$];
  int          pulses;
  int          sel_bad;
  int          first_sel_cyc;
  int          exec_cyc;
  logic [1:0]  prev_status = 2'b00;
  bit          rand_grant = 1'b0;

  // Memory contents seen by reads: a fixed function of address and per-test seed.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a, input logic [31:0] s);
    logic [15:0] lo;
    lo = a * 16'h9E37 + s[31:16];
    return {a ^ s[15:0], lo};
  endfunction

  assign bus_if.m_din = rd_fn(bus_if.m_addr, seed);

  task automatic refresh_fifo();
    fifo_empty = (fq.size() == 0);
    if (fq.size() > 0) begin
      fifo_src_addr  = fq[0].src;
      fifo_dest_addr = fq[0].dest;
      fifo_data_size = fq[0].size;
    end else begin
      fifo_src_addr  = '0;
      fifo_dest_addr = '0;
      fifo_data_size = '0;
    end
  endtask

  // One clock step: observe DUT outputs at the falling edge, then update stimulus.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fifo_rd_en) begin
      pulses++;
      if (fq.size() > 0) void'(fq.pop_front());
      refresh_fifo();
    end
    if (bus_if.m_sel) begin
      log_q.push_back('{bus_if.m_wr, bus_if.m_addr, bus_if.m_wr ? bus_if.m_dout : '0});
      log_cyc.push_back(cyc);
      if (!bus_if.m_grant) sel_bad++;
      if (first_sel_cyc < 0) first_sel_cyc = cyc;
    end
    if (status == 2'b01 && prev_status != 2'b01) exec_cyc = cyc;
    prev_status = status;
    if (rand_grant) bus_if.m_grant = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: every word is a read of src(+i) then a write of that data to dest(+i).
  task automatic build_exp(input logic [1:0] mode);
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    exp_q.delete();
    foreach (plan_q[k]) begin
      for (int i = 0; i < int'(plan_q[k].size); i++) begin
        s = plan_q[k].src  + ((mode == 2'b01) ? 16'd0 : AW'(i));
        d = plan_q[k].dest + ((mode == 2'b10) ? 16'd0 : AW'(i));
        exp_q.push_back('{1'b0, s, '0});
        exp_q.push_back('{1'b1, d, rd_fn(s, seed)});
      end
    end
  endtask

  function automatic int log_mismatches();
    int m;
    int n;
    m = (log_q.size() > exp_q.size()) ? log_q.size() - exp_q.size() : exp_q.size() - log_q.size();
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic start_run(input logic [1:0] mode);
    log_q.delete();
    log_cyc.delete();
    pulses        = 0;
    sel_bad       = 0;
    first_sel_cyc = -1;
    exec_cyc      = -1;
    fq            = plan_q;
    refresh_fifo();
    op_mode       = mode;
    build_exp(mode);
    op_start      = 1'b1;
    tick();
  endtask

  // Runs the plan to DONE; optional grant drop of drop_len cycles right after the first read.
  task automatic run_op(input logic [1:0] mode, input bit hold, input int drop_len, input string nm);
    int n;
    int drop_cnt;
    bit dropped;
    n = 0;
    drop_cnt = 0;
    dropped = 1'b0;
    start_run(mode);
    if (!hold) op_start = 1'b0;
    while (status != 2'b10 && n < 4000) begin
      if (drop_len > 0 && !dropped && log_q.size() == 1) begin
        bus_if.m_grant = 1'b0;
        dropped  = 1'b1;
        drop_cnt = drop_len;
      end
      tick();
      n++;
      if (dropped && drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) bus_if.m_grant = 1'b1;
      end
    end
    total++;
    if (status !== 2'b10)
      begin bad++; $display("FAIL %s_done status=%b expected=10", nm, status); end
  endtask

  task automatic do_clear();
    opdone_clear = 1'b1;
    tick();
    opdone_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total += 7;
    if (status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b expected=00", status); end
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_fifo_rd_en got=%b expected=0", fifo_rd_en); end
    if (bus_if.m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%b expected=0", bus_if.m_req); end
    if (bus_if.m_sel !== 1'b0) begin bad++; $display("FAIL reset_m_sel got=%b expected=0", bus_if.m_sel); end
    if (bus_if.m_wr !== 1'b0) begin bad++; $display("FAIL reset_m_wr got=%b expected=0", bus_if.m_wr); end
    if (bus_if.m_addr !== '0) begin bad++; $display("FAIL reset_m_addr got=%h expected=0000", bus_if.m_addr); end
    if (bus_if.m_dout !== '0) begin bad++; $display("FAIL reset_m_dout got=%h expected=0", bus_if.m_dout); end
    reset_n = 1'b1;
    tick();
    $display("test_reset: outputs checked");
  endtask

  task automatic test_basic();
    int nm;
    seed = $urandom;
    plan_q = '{'{16'h0010, 16'h0040, 5'd3}};
    run_op(2'b00, 1'b0, 0, "basic");
    nm = log_mismatches();
    total += 4;
    if (nm != 0) begin bad++; $display("FAIL basic_log mismatches=%0d expected=0 (len %0d vs %0d)", nm, log_q.size(), exp_q.size()); end
    if (pulses != 1) begin bad++; $display("FAIL basic_pops got=%0d expected=1", pulses); end
    // EXEC shown, then first read strobe three cycles later
    if (first_sel_cyc - exec_cyc != 3) begin bad++; $display("FAIL basic_latency got=%0d expected=3", first_sel_cyc - exec_cyc); end
    if (log_cyc.size() >= 3 && log_cyc[2] - log_cyc[0] != 3) begin bad++; $display("FAIL basic_word_period got=%0d expected=3", log_cyc[2] - log_cyc[0]); end
    do_clear();
    total++;
    if (status !== 2'b00) begin bad++; $display("FAIL basic_clear status=%b expected=00", status); end
    $display("test_basic: %0d bus cycles logged", log_q.size());
  endtask

  task automatic test_modes();
    int nm;
    for (int m = 1; m < 4; m++) begin
      seed = $urandom;
      plan_q = '{'{16'h0020, 16'h0050, 5'd4}};
      run_op(2'(m), 1'b0, 0, "modes");
      nm = log_mismatches();
      total++;
      if (nm != 0) begin bad++; $display("FAIL mode%0d_log mismatches=%0d expected=0", m, nm); end
      do_clear();
      $display("test_modes: mode %0d, %0d bus cycles", m, log_q.size());
    end
  endtask

  task automatic test_size_zero();
    int nm;
    seed = $urandom;
    plan_q = '{'{16'h0100, 16'h0200, 5'd0}, '{16'h0030, 16'h0060, 5'd2}};
    run_op(2'b00, 1'b0, 0, "size0");
    nm = log_mismatches();
    total += 3;
    if (nm != 0) begin bad++; $display("FAIL size0_log mismatches=%0d expected=0", nm); end
    if (pulses != 2) begin bad++; $display("FAIL size0_pops got=%0d expected=2", pulses); end
    if (log_q.size() != 4) begin bad++; $display("FAIL size0_bus_cycles got=%0d expected=4", log_q.size()); end
    do_clear();
    $display("test_size_zero: pops=%0d", pulses);
  endtask

  task automatic test_wrap_stall();
    int nm;
    seed = $urandom;
    plan_q = '{'{16'hFFFE, 16'h1234, 5'd3}};
    run_op(2'b00, 1'b0, 5, "wrap");
    nm = log_mismatches();
    total += 3;
    if (nm != 0) begin bad++; $display("FAIL wrap_log mismatches=%0d expected=0", nm); end
    if (sel_bad != 0) begin bad++; $display("FAIL wrap_sel_no_grant got=%0d expected=0", sel_bad); end
    // Grant low for 5 edges starting at RDW: write strobe arrives 4 cycles late.
    if (log_cyc.size() >= 2 && log_cyc[1] - log_cyc[0] != 6) begin bad++; $display("FAIL wrap_stall_gap got=%0d expected=6", log_cyc[1] - log_cyc[0]); end
    do_clear();
    $display("test_wrap_stall: %0d bus cycles", log_q.size());
  endtask

  task automatic test_start_held();
    int n;
    seed = $urandom;
    plan_q = '{'{16'h0300, 16'h0400, 5'd1}};
    run_op(2'b00, 1'b1, 0, "held");
    do_clear();
    plan_q = '{'{16'h0500, 16'h0600, 5'd2}};
    fq = plan_q;
    refresh_fifo();
    pulses = 0;
    log_q.delete();
    repeat (12) tick();
    total += 3;
    if (status !== 2'b00) begin bad++; $display("FAIL held_status got=%b expected=00", status); end
    if (pulses != 0) begin bad++; $display("FAIL held_pops got=%0d expected=0", pulses); end
    if (log_q.size() != 0) begin bad++; $display("FAIL held_bus_cycles got=%0d expected=0", log_q.size()); end
    op_start = 1'b0;
    tick();
    $display("test_start_held: no restart");

    plan_q = '{'{16'h0700, 16'h0800, 5'd4}};
    start_run(2'b00);
    op_start = 1'b0;
    n = 0;
    while (bus_if.m_req !== 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (bus_if.m_req !== 1'b1) begin bad++; $display("FAIL abort_reach_rd m_req=%b expected=1", bus_if.m_req); end
    reset_n = 1'b0;
    tick();
    total += 6;
    if (status !== 2'b00) begin bad++; $display("FAIL abort_status got=%b expected=00", status); end
    if (bus_if.m_req !== 1'b0) begin bad++; $display("FAIL abort_m_req got=%b expected=0", bus_if.m_req); end
    if (bus_if.m_sel !== 1'b0) begin bad++; $display("FAIL abort_m_sel got=%b expected=0", bus_if.m_sel); end
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL abort_fifo_rd_en got=%b expected=0", fifo_rd_en); end
    if (bus_if.m_addr !== '0) begin bad++; $display("FAIL abort_m_addr got=%h expected=0000", bus_if.m_addr); end
    if (bus_if.m_dout !== '0) begin bad++; $display("FAIL abort_m_dout got=%h expected=0", bus_if.m_dout); end
    reset_n = 1'b1;
    repeat (3) tick();
    total++;
    if (status !== 2'b00) begin bad++; $display("FAIL abort_idle status=%b expected=00", status); end
    $display("test_start_held: reset abort checked");
  endtask

`ifdef DMAC_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    plan_q = '{'{16'h0010, 16'h0020, 5'd2}};
    bus_if.m_grant = 1'b0;
    start_run(2'b00);
    op_start = 1'b0;
    n = 0;
    while (status != 2'b11 && n < 400) begin tick(); n++; end
    total += 4;
    if (status !== 2'b11) begin bad++; $display("FAIL timeout_status got=%b expected=11", status); end
    if (bus_if.m_req !== 1'b0) begin bad++; $display("FAIL timeout_m_req got=%b expected=0", bus_if.m_req); end
    // RD is reached 2 cycles after EXEC, then 255 stalled cycles.
    if (cyc - exec_cyc != 257) begin bad++; $display("FAIL timeout_cycles got=%0d expected=257", cyc - exec_cyc); end
    if (log_q.size() != 0) begin bad++; $display("FAIL timeout_bus_cycles got=%0d expected=0", log_q.size()); end
    bus_if.m_grant = 1'b1;
    do_clear();
    total++;
    if (status !== 2'b00) begin bad++; $display("FAIL timeout_clear status=%b expected=00", status); end
    $display("test_timeout: error status reached");
  endtask
`endif

  task automatic test_random();
    int nm;
    int nd;
    desc_t d;
    for (int it = 0; it < 16; it++) begin
      seed = $urandom;
      rand_grant = it[0];
      plan_q.delete();
      nd = $urandom_range(1, 3);
      for (int k = 0; k < nd; k++) begin
        d.src  = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom);
        d.dest = AW'($urandom);
        d.size = SW'($urandom_range(0, 12));
        plan_q.push_back(d);
      end
      run_op(2'($urandom_range(0, 3)), 1'b0, 0, "random");
      nm = log_mismatches();
      total += 3;
      if (nm != 0) begin bad++; $display("FAIL random%0d_log mismatches=%0d expected=0", it, nm); end
      if (sel_bad != 0) begin bad++; $display("FAIL random%0d_sel_no_grant got=%0d expected=0", it, sel_bad); end
      if (pulses != nd) begin bad++; $display("FAIL random%0d_pops got=%0d expected=%0d", it, pulses, nd); end
      rand_grant = 1'b0;
      bus_if.m_grant = 1'b1;
      do_clear();
      total++;
      if (status !== 2'b00) begin bad++; $display("FAIL random%0d_clear status=%b expected=00", it, status); end
      $display("test_random: iter %0d descs=%0d bus cycles=%0d", it, nd, log_q.size());
    end
  endtask

  initial begin
    bus_if.m_grant = 1'b1;
    refresh_fifo();
    test_reset();
    test_basic();
    test_modes();
    test_size_zero();
    test_wrap_stall();
    test_start_held();
`ifdef DMAC_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
